// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } div_state_e;

    localparam logic [MAX_W-1:0] DIV_ZERO_QUO = '1;

    // Caller sign-extends the operand to MAX_W and truncates the result.
    function automatic logic [MAX_W-1:0] abs_val(
        input logic [MAX_W-1:0] value,
        input logic             is_signed
    );
        return (is_signed && value[MAX_W-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted  = {rem, quo_msb};
        trial    = shifted - {1'b0, divisor_mag};
        q_bit    = ~trial[WIDTH];
        next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned restoring divider with start/busy/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] dd_q, dd_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem_q),
        .quo_msb    (quo_q[WIDTH-1]),
        .divisor_mag(dvsr_q),
        .next_rem   (step_rem),
        .q_bit      (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        dd_d        = dd_q;
        dv_d        = dv_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dd_d     = dividend;
                    dv_d     = divisor;
                    signed_d = is_signed;
                    dbz_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = PREP;
                end
            end
            PREP: begin
                // The dividend magnitude seeds the quotient half of {rem,quo}.
                quo_d  = WIDTH'(abs_val(MAX_W'($signed(dd_q)), signed_q));
                dvsr_d = WIDTH'(abs_val(MAX_W'($signed(dv_q)), signed_q));
                rem_d  = '0;
                cnt_d  = CNT_W'(WIDTH);
                qneg_d = signed_q & (dd_q[WIDTH-1] ^ dv_q[WIDTH-1]);
                rneg_d = signed_q & dd_q[WIDTH-1];
                zero_d = (dv_q == '0);
                state_d = (dv_q == '0) ? FIX : ITER;
            end
            ITER: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d  = WIDTH'(DIV_ZERO_QUO);
                    remainder_d = dd_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = qneg_q ? -quo_q : quo_q;
                    remainder_d = rneg_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            dd_q        <= '0;
            dv_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            signed_q    <= signed_d;
            dd_q        <= dd_d;
            dv_q        <= dv_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
